range_image_projector: RTL
==========================

// Module: range_image_projector
// PURPOSE
//  Stage 2 of the range-image pipeline. Pops (h,v,r) points from the Stage 1 point FIFO,
//  maps each point to a (row,col) cell, and z-buffers it into an external range-image RAM.
//  Each cell keeps the nearest radius. Clears the image at frame start and signals frame
//  completion once Stage 1 has delivered every point and the FIFO has drained.
// PARAMETERS
//  ROW_BITS  6        log2 image rows (64)
//  COL_BITS  11       log2 image cols (2048); COLS = 1<<COL_BITS
//  H_SHIFT   5        col = point_h >> H_SHIFT (16-bit azimuth code -> COL_BITS)
//  V_SHIFT   4        row = (point_v - V_MIN) >> V_SHIFT
//  V_MIN     -16'sd512  signed elevation code mapped to row 0
//  EMPTY_R   16'hFFFF   cell value meaning "no return"
// PORTS
//  i_clk          in   1   clock
//  i_rst          in   1   synchronous reset, active high
//  i_enable       in   1   frame enable; deassert to return to IDLE after done
//  i_point_h      in   16  FIFO head azimuth (unsigned code)
//  i_point_v      in   16  FIFO head elevation (signed two's complement code)
//  i_point_r      in   16  FIFO head radius; 0 = invalid return
//  i_fifo_empty   in   1   Stage 1 FIFO empty
//  o_rd_fifo      out  1   one-cycle FIFO pop; data valid on i_point_* the cycle after
//  i_allpoints    in   1   Stage 1 has read all points of the frame
//  o_img_addr     out  ROW_BITS+COL_BITS  RAM address = {row,col}
//  o_img_en       out  1   RAM enable; read data on i_img_rdata 1 cycle after en & !we
//  o_img_we       out  1   RAM write enable
//  o_img_wdata    out  16  RAM write data
//  i_img_rdata    in   16  RAM read data
//  o_busy         out  1   high in any state except IDLE/DONE
//  o_done         out  1   level, high in DONE
//  o_written      out  19  cells updated this frame
//  o_dropped      out  19  points rejected this frame
// BEHAVIOUR
//  Reset: state=IDLE; o_rd_fifo, o_img_en, o_img_we, o_busy, o_done = 0; o_img_addr,
//   o_img_wdata = 0; counters = 0. Reset mid-frame aborts at once; no further RAM writes.
//  FSM:
//   IDLE  - i_enable -> CLEAR; clear counters.
//   CLEAR - write EMPTY_R to addr 0..2^(ROW_BITS+COL_BITS)-1, one per cycle; last -> WAIT.
//   WAIT  - !i_fifo_empty -> POP.
//         - else if i_allpoints -> DONE.
//         - else stay.
//   POP   - o_rd_fifo=1 for exactly this cycle -> LATCH.
//   LATCH - register h,v,r.
//         - Compute voff = $signed(v) - V_MIN in 17-bit signed.
//         - Drop if r==0, voff<0, (voff>>V_SHIFT)>=2^ROW_BITS, or (h>>H_SHIFT)>=COLS.
//         - Drop: o_dropped++, then WAIT. Else -> RD.
//   RD    - o_img_en=1, we=0, addr={row,col} -> CMP.
//   CMP   - rdata valid.
//         - If r < rdata (unsigned): write r to same addr (en=we=1), o_written++.
//         - Else no write. Either way -> WAIT.
//   DONE  - o_done=1 -> IDLE when i_enable==0.
//  Timing: 5 cycles per accepted point (WAIT,POP,LATCH,RD,CMP); 3 per dropped point.
//  Equal radius keeps the stored value. o_written counts writes, not distinct cells.
//  Boundaries:
//   - CLEAR ignores the FIFO.
//   - i_allpoints with FIFO non-empty keeps draining; DONE only when both hold in WAIT.
//   - Counters saturate at 19'h7FFFF.
//   - No RAW hazard: strictly one point in flight.
//   - o_img_en/o_img_we are low in all states except CLEAR, RD and CMP-write.
// STRUCTURE
//  Shared package range_image_pkg: image geometry params, EMPTY_R, state encodings
//   (S_IDLE, S_CLEAR, S_WAIT, S_POP, S_LATCH, S_RD, S_CMP, S_DONE).
//  One sub-module, ri_cell_mapper: combinational (h,v,r) -> {row,col,drop}, reused by
//   Stage 3 lookup.
// TESTING
//  1 Frame with FIFO empty, i_allpoints=1 -> 2^17 EMPTY_R writes, then o_done, o_written=0.
//  2 Point h=0x0040,v=0,r=100 -> addr {row=32,col=2} (row=(0+512)>>4=32) written 100,
//    o_written=1, 5 cycles.
//  3 Same cell r=100, then r=50, then r=80 -> final value 50, o_written=2.
//  4 Points r=0; v=-600; v=0x0200 (row 64) -> no RAM writes, o_dropped=3.
//  5 FIFO alternates empty/non-empty with i_allpoints raised early -> all 10 points
//    processed before o_done.
//  6 i_rst asserted in CMP -> no write that cycle, outputs at reset values next cycle.

Source files
------------

// File: rtl/range_image_pkg.sv
// Shared definitions for the range-image pipeline: default image geometry,
// the empty-cell marker and the Stage 2 projector state encoding.
package range_image_pkg;

    localparam int                 IMG_ROW_BITS = 6;
    localparam int                 IMG_COL_BITS = 11;
    localparam int                 IMG_H_SHIFT  = 5;
    localparam int                 IMG_V_SHIFT  = 4;
    localparam logic signed [15:0] IMG_V_MIN    = -16'sd512;
    localparam logic [15:0]        EMPTY_R      = 16'hFFFF;
    localparam int                 CNT_W        = 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_POP,
        S_LATCH,
        S_RD,
        S_CMP,
        S_DONE
    } state_e;

endpackage

// File: rtl/ri_cell_mapper.sv
// Combinational (h,v,r) -> (row,col,drop) mapping, shared with the Stage 3
// lookup so both stages agree on which cell a point lands in.
module ri_cell_mapper
    import range_image_pkg::*;
#(
    parameter int                 ROW_BITS = IMG_ROW_BITS,
    parameter int                 COL_BITS = IMG_COL_BITS,
    parameter int                 H_SHIFT  = IMG_H_SHIFT,
    parameter int                 V_SHIFT  = IMG_V_SHIFT,
    parameter logic signed [15:0] V_MIN    = IMG_V_MIN
) (
    input  logic [15:0]         h_i,
    input  logic [15:0]         v_i,
    input  logic [15:0]         r_i,
    output logic [ROW_BITS-1:0] row_o,
    output logic [COL_BITS-1:0] col_o,
    output logic                drop_o
);

    logic signed [16:0] voff;
    logic [15:0]        row_full;
    logic [15:0]        col_full;
    logic               row_ovf;
    logic               col_ovf;

    // 17 bits keeps the subtraction exact for any 16-bit elevation code;
    // a non-negative result always fits in the low 16 bits.
    assign voff     = $signed({v_i[15], v_i}) - $signed({V_MIN[15], V_MIN});
    assign row_full = voff[15:0] >> V_SHIFT;
    assign col_full = h_i >> H_SHIFT;
    assign row_ovf  = (row_full >> ROW_BITS) != 16'd0;
    assign col_ovf  = (col_full >> COL_BITS) != 16'd0;

    assign row_o  = row_full[ROW_BITS-1:0];
    assign col_o  = col_full[COL_BITS-1:0];
    assign drop_o = (r_i == 16'd0) | voff[16] | row_ovf | col_ovf;

endmodule

// File: rtl/range_image_projector.sv
// Stage 2: clears the range image, then z-buffers FIFO points into it one at a
// time (nearest radius wins) and flags the frame done once the FIFO drains.
module range_image_projector
    import range_image_pkg::*;
#(
    parameter int                 ROW_BITS = IMG_ROW_BITS,
    parameter int                 COL_BITS = IMG_COL_BITS,
    parameter int                 H_SHIFT  = IMG_H_SHIFT,
    parameter int                 V_SHIFT  = IMG_V_SHIFT,
    parameter logic signed [15:0] V_MIN    = IMG_V_MIN
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_enable,
    input  logic [15:0]                  i_point_h,
    input  logic [15:0]                  i_point_v,
    input  logic [15:0]                  i_point_r,
    input  logic                         i_fifo_empty,
    output logic                         o_rd_fifo,
    input  logic                         i_allpoints,
    output logic [ROW_BITS+COL_BITS-1:0] o_img_addr,
    output logic                         o_img_en,
    output logic                         o_img_we,
    output logic [15:0]                  o_img_wdata,
    input  logic [15:0]                  i_img_rdata,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [CNT_W-1:0]             o_written,
    output logic [CNT_W-1:0]             o_dropped
);

    localparam int              AW      = ROW_BITS + COL_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_addr_q;
    logic [AW-1:0]     cell_addr_q;
    logic [15:0]       r_q;
    logic [CNT_W-1:0]  written_q;
    logic [CNT_W-1:0]  dropped_q;

    logic [ROW_BITS-1:0] map_row;
    logic [COL_BITS-1:0] map_col;
    logic                map_drop;
    logic                write_hit;

    logic                rd_fifo_c;
    logic                en_c;
    logic                we_c;
    logic [AW-1:0]       addr_c;
    logic [15:0]         wdata_c;

    ri_cell_mapper #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .H_SHIFT  (H_SHIFT),
        .V_SHIFT  (V_SHIFT),
        .V_MIN    (V_MIN)
    ) u_mapper (
        .h_i    (i_point_h),
        .v_i    (i_point_v),
        .r_i    (i_point_r),
        .row_o  (map_row),
        .col_o  (map_col),
        .drop_o (map_drop)
    );

    // Strictly nearer wins; an equal radius leaves the stored value alone.
    assign write_hit = (state_q == S_CMP) && (r_q < i_img_rdata);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_enable) state_d = S_CLEAR;
            S_CLEAR: if (clr_addr_q == '1) state_d = S_WAIT;
            S_WAIT: begin
                if (!i_fifo_empty)    state_d = S_POP;
                else if (i_allpoints) state_d = S_DONE;
            end
            S_POP:   state_d = S_LATCH;
            S_LATCH: state_d = map_drop ? S_WAIT : S_RD;
            S_RD:    state_d = S_CMP;
            S_CMP:   state_d = S_WAIT;
            S_DONE:  if (!i_enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clr_addr_q  <= '0;
            cell_addr_q <= '0;
            r_q         <= '0;
            written_q   <= '0;
            dropped_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_enable) begin
                        clr_addr_q <= '0;
                        written_q  <= '0;
                        dropped_q  <= '0;
                    end
                end
                S_CLEAR: clr_addr_q <= clr_addr_q + 1'b1;
                S_LATCH: begin
                    r_q         <= i_point_r;
                    cell_addr_q <= {map_row, map_col};
                    if (map_drop && dropped_q != CNT_MAX) dropped_q <= dropped_q + 1'b1;
                end
                S_CMP: begin
                    if (write_hit && written_q != CNT_MAX) written_q <= written_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_fifo_c = 1'b0;
        en_c      = 1'b0;
        we_c      = 1'b0;
        addr_c    = '0;
        wdata_c   = '0;
        case (state_q)
            S_CLEAR: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = clr_addr_q;
                wdata_c = EMPTY_R;
            end
            S_POP: rd_fifo_c = 1'b1;
            S_RD: begin
                en_c   = 1'b1;
                addr_c = cell_addr_q;
            end
            S_CMP: begin
                en_c    = write_hit;
                we_c    = write_hit;
                addr_c  = cell_addr_q;
                wdata_c = write_hit ? r_q : 16'd0;
            end
            default: ;
        endcase
    end

    // Reset kills any strobe in the same cycle so an abort never lands a write.
    assign o_rd_fifo   = rd_fifo_c & ~i_rst;
    assign o_img_en    = en_c & ~i_rst;
    assign o_img_we    = we_c & ~i_rst;
    assign o_img_addr  = addr_c;
    assign o_img_wdata = wdata_c;
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done      = (state_q == S_DONE);
    assign o_written   = written_q;
    assign o_dropped   = dropped_q;

endmodule
